// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word reads to the memory controller and
// holds one instruction for IF/ID. Define IF_ICACHE_EN to add a direct-mapped instruction cache.
module if_fetch
`ifdef IF_ICACHE_EN
#(
    parameter int unsigned ICACHE_ENTRIES = 16
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        jump_in,
    input  logic [31:0] jump_addr_in,
    input  logic        mem_busy_in,
    input  logic        get_inst_in,
    input  logic [31:0] inst_pc_in,
    input  logic [31:0] inst_in,
    output logic        if_req_out,
    output logic [31:0] if_addr_out,
    output logic        valid_out,
    output logic [31:0] pc_out,
    output logic [31:0] inst_out
);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;

    logic        match;
    logic        hit;
    logic [31:0] hit_inst;
    logic        fill;

    // Busy is informational only; the low PC bits of a redirect are forced to zero.
    logic unused_inputs;
    assign unused_inputs = ^{mem_busy_in, jump_addr_in[1:0]};

    assign match = get_inst_in && (inst_pc_in == fetch_pc_q);
    assign fill  = (state_q == StFetch) && match && !hit && !jump_in;

`ifdef IF_ICACHE_EN
    localparam int unsigned IdxW = $clog2(ICACHE_ENTRIES);
    localparam int unsigned TagW = 32 - IdxW - 2;

    logic [ICACHE_ENTRIES-1:0] line_valid_q;
    logic [TagW-1:0]           line_tag_q  [ICACHE_ENTRIES];
    logic [31:0]               line_data_q [ICACHE_ENTRIES];
    logic [IdxW-1:0]           idx;
    logic [TagW-1:0]           tag;

    assign idx      = fetch_pc_q[IdxW+1:2];
    assign tag      = fetch_pc_q[31:IdxW+2];
    assign hit      = (state_q == StFetch) && line_valid_q[idx] && (line_tag_q[idx] == tag);
    assign hit_inst = line_data_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            line_valid_q <= '0;
        end else if (fill) begin
            line_valid_q[idx] <= 1'b1;
        end
    end

    // Data and tag need no reset: they are qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (fill) begin
            line_tag_q[idx]  <= tag;
            line_data_q[idx] <= inst_in;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_inst = '0;
`endif

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        if (jump_in) begin
            // A redirect discards any held word and any same-cycle response.
            fetch_pc_d = {jump_addr_in[31:2], 2'b00};
            valid_d    = 1'b0;
            state_d    = StFetch;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StFetch;
                end
                StFetch: begin
                    if (hit || match) begin
                        pc_d       = fetch_pc_q;
                        inst_d     = hit ? hit_inst : inst_in;
                        valid_d    = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = StHold;
                    end
                end
                StHold: begin
                    if (!stall_in) begin
                        valid_d = 1'b0;
                        state_d = StFetch;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            fetch_pc_q <= '0;
            pc_q       <= '0;
            inst_q     <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
        end
    end

    // Must drop in the response cycle itself, or the controller restarts the same read.
    assign if_req_out  = (state_q == StFetch) && !match && !hit && !jump_in;
    assign if_addr_out = fetch_pc_q;
    assign valid_out   = valid_q;
    assign pc_out      = pc_q;
    assign inst_out    = inst_q;

endmodule

// File: tb/tb_if_fetch.sv
// Directed scenarios plus a randomized run against a controller model and a
// program-order scoreboard for the fetch stage.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_in;
    logic        jump_in;
    logic [31:0] jump_addr_in;
    logic        mem_busy_in;
    logic        get_inst_in;
    logic [31:0] inst_pc_in;
    logic [31:0] inst_in;
    logic        if_req_out;
    logic [31:0] if_addr_out;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] inst_out;

    int n_pass  = 0;
    int n_total = 0;

    if_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall_in     (stall_in),
        .jump_in      (jump_in),
        .jump_addr_in (jump_addr_in),
        .mem_busy_in  (mem_busy_in),
        .get_inst_in  (get_inst_in),
        .inst_pc_in   (inst_pc_in),
        .inst_in      (inst_in),
        .if_req_out   (if_req_out),
        .if_addr_out  (if_addr_out),
        .valid_out    (valid_out),
        .pc_out       (pc_out),
        .inst_out     (inst_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h5a5a, ~a[31:16]} ^ 32'h0000_0013;
    endfunction

    // Every task starts and ends just after a falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; stall_in = 1'b0; jump_in = 1'b0; jump_addr_in = '0; mem_busy_in = 1'b0;
        get_inst_in = 1'b0; inst_pc_in = '0; inst_in = '0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_total++; if (valid_out !== 1'b0) $display("FAIL reset_valid got=%0b exp=0", valid_out); else n_pass++;
        n_total++; if (pc_out !== 32'h0) $display("FAIL reset_pc got=%h exp=0", pc_out); else n_pass++;
        n_total++; if (inst_out !== 32'h0) $display("FAIL reset_inst got=%h exp=0", inst_out); else n_pass++;
        n_total++; if (if_addr_out !== 32'h0) $display("FAIL reset_addr got=%h exp=0", if_addr_out); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++; if (if_req_out !== 1'b0) $display("FAIL idle_req got=%0b exp=0", if_req_out); else n_pass++;
    endtask

    task automatic test_first_fetch();
        tick();
        for (int i = 0; i < 6; i++) begin
            n_total++; if (if_req_out !== 1'b1) $display("FAIL first_req c%0d got=%0b exp=1", i, if_req_out); else n_pass++;
            tick();
        end
        get_inst_in = 1'b1; inst_pc_in = 32'h0; inst_in = 32'h0000_0013;
        #1;
        n_total++; if (if_req_out !== 1'b0) $display("FAIL resp_cycle_req got=%0b exp=0", if_req_out); else n_pass++;
        tick();
        n_total++; if (valid_out !== 1'b1) $display("FAIL first_valid got=%0b exp=1", valid_out); else n_pass++;
        n_total++; if (pc_out !== 32'h0) $display("FAIL first_pc got=%h exp=0", pc_out); else n_pass++;
        n_total++; if (inst_out !== 32'h13) $display("FAIL first_inst got=%h exp=13", inst_out); else n_pass++;
        n_total++; if (if_addr_out !== 32'h4) $display("FAIL first_next_addr got=%h exp=4", if_addr_out); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 4; i++) begin
            stall_in = (i < 3);
            #1;
            n_total++; if (valid_out !== 1'b1) $display("FAIL stall_valid c%0d got=%0b exp=1", i, valid_out); else n_pass++;
            n_total++; if ({pc_out, inst_out} !== {32'h0, 32'h13})
                $display("FAIL stall_hold c%0d got=%h/%h exp=0/13", i, pc_out, inst_out); else n_pass++;
            tick();
        end
        n_total++; if (valid_out !== 1'b0) $display("FAIL stall_release got=%0b exp=0", valid_out); else n_pass++;
        n_total++; if (if_req_out !== 1'b1) $display("FAIL stall_next_req got=%0b exp=1", if_req_out); else n_pass++;
        n_total++; if (if_addr_out !== 32'h4) $display("FAIL stall_next_addr got=%h exp=4", if_addr_out); else n_pass++;
        get_inst_in = 1'b0;
    endtask

    task automatic test_jump_mid_fetch();
        get_inst_in = 1'b1; inst_pc_in = 32'h4; inst_in = 32'haaaa_0004;
        tick();
        get_inst_in = 1'b0;
        tick();
        n_total++; if (if_addr_out !== 32'h8) $display("FAIL jmf_addr8 got=%h exp=8", if_addr_out); else n_pass++;
        tick();
        jump_in = 1'b1; jump_addr_in = 32'h100;
        #1;
        n_total++; if (if_req_out !== 1'b0) $display("FAIL jmf_jump_req got=%0b exp=0", if_req_out); else n_pass++;
        tick();
        jump_in = 1'b0;
        n_total++; if (if_addr_out !== 32'h100) $display("FAIL jmf_target got=%h exp=100", if_addr_out); else n_pass++;
        get_inst_in = 1'b1; inst_pc_in = 32'h8; inst_in = 32'hdead_0008;
        #1;
        n_total++; if (if_req_out !== 1'b1) $display("FAIL jmf_stale_req got=%0b exp=1", if_req_out); else n_pass++;
        tick();
        get_inst_in = 1'b0;
        n_total++; if (valid_out !== 1'b0) $display("FAIL jmf_stale_valid got=%0b exp=0", valid_out); else n_pass++;
        tick();
        n_total++; if (valid_out !== 1'b0) $display("FAIL jmf_wait_valid got=%0b exp=0", valid_out); else n_pass++;
        get_inst_in = 1'b1; inst_pc_in = 32'h100; inst_in = 32'hcafe_0100;
        tick();
        get_inst_in = 1'b0;
        n_total++; if ({valid_out, pc_out, inst_out} !== {1'b1, 32'h100, 32'hcafe_0100})
            $display("FAIL jmf_deliver got=%0b/%h/%h exp=1/100/cafe0100", valid_out, pc_out, inst_out); else n_pass++;
        tick();
    endtask

    task automatic test_jump_match();
        get_inst_in = 1'b1; inst_pc_in = 32'h104; inst_in = 32'h1111_0104;
        jump_in = 1'b1; jump_addr_in = 32'h203;
        tick();
        jump_in = 1'b0; get_inst_in = 1'b0;
        n_total++; if (valid_out !== 1'b0) $display("FAIL jm_valid got=%0b exp=0", valid_out); else n_pass++;
        n_total++; if (if_addr_out !== 32'h200) $display("FAIL jm_target got=%h exp=200", if_addr_out); else n_pass++;
        get_inst_in = 1'b1; inst_pc_in = 32'h200; inst_in = 32'h0020_0000;
        tick();
        get_inst_in = 1'b0;
        n_total++; if (valid_out !== 1'b1) $display("FAIL jm_hold_valid got=%0b exp=1", valid_out); else n_pass++;
        stall_in = 1'b1; jump_in = 1'b1; jump_addr_in = 32'h40;
        tick();
        stall_in = 1'b0; jump_in = 1'b0;
        n_total++; if (valid_out !== 1'b0) $display("FAIL jump_stall_valid got=%0b exp=0", valid_out); else n_pass++;
        n_total++; if (if_addr_out !== 32'h40) $display("FAIL jump_stall_addr got=%h exp=40", if_addr_out); else n_pass++;
    endtask

    task automatic test_wrap();
        jump_in = 1'b1; jump_addr_in = 32'hffff_fffc;
        tick();
        jump_in = 1'b0;
        get_inst_in = 1'b1; inst_pc_in = 32'hffff_fffc; inst_in = 32'h0000_006f;
        tick();
        get_inst_in = 1'b0;
        n_total++; if (pc_out !== 32'hffff_fffc) $display("FAIL wrap_pc got=%h exp=fffffffc", pc_out); else n_pass++;
        n_total++; if (if_addr_out !== 32'h0) $display("FAIL wrap_addr got=%h exp=0", if_addr_out); else n_pass++;
        tick();
    endtask

    // Controller model: latches a request, answers after a random latency, and holds the
    // response until it sees the next request.
    task automatic test_random();
        logic        ctl_busy = 1'b0;
        logic        ctl_resp = 1'b0;
        logic [31:0] ctl_addr = '0;
        int          ctl_cnt  = 0;
        logic [31:0] exp_pc   = '0;
        int          n_insts  = 0;
        logic        v, s, j, r;
        logic [31:0] p, ins, a, tgt;
        do_reset();
        rst = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            stall_in = ($urandom_range(0, 2) == 0);
            jump_in  = ($urandom_range(0, 19) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? (32'hffff_fff0 | $urandom_range(0, 15))
                                              : ($urandom & 32'h0000_03ff);
            jump_addr_in = tgt;
            get_inst_in  = ctl_resp;
            inst_pc_in   = ctl_addr;
            inst_in      = mem_word(ctl_addr);
            #1;
            if (jump_in || (get_inst_in && inst_pc_in == if_addr_out)) begin
                n_total++; if (if_req_out !== 1'b0)
                    $display("FAIL rnd_req_low c%0d got=%0b exp=0", c, if_req_out); else n_pass++;
            end
            v = valid_out; s = stall_in; j = jump_in; p = pc_out; ins = inst_out;
            r = if_req_out; a = if_addr_out;
            @(posedge clk);
            if (ctl_resp) begin
                if (r) begin
                    ctl_resp = 1'b0; ctl_busy = 1'b1; ctl_addr = a; ctl_cnt = $urandom_range(1, 4);
                end
            end else if (ctl_busy) begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    ctl_busy = 1'b0; ctl_resp = 1'b1;
                end
            end else if (r) begin
                ctl_busy = 1'b1; ctl_addr = a; ctl_cnt = $urandom_range(1, 4);
            end
            @(negedge clk);
            if (j) begin
                exp_pc = {tgt[31:2], 2'b00};
                n_total++; if ({valid_out, if_addr_out} !== {1'b0, exp_pc})
                    $display("FAIL rnd_jump c%0d got=%0b/%h exp=0/%h", c, valid_out, if_addr_out, exp_pc);
                else n_pass++;
            end else if (v && s) begin
                n_total++; if ({valid_out, pc_out, inst_out} !== {1'b1, p, ins})
                    $display("FAIL rnd_stall_hold c%0d got=%0b/%h/%h exp=1/%h/%h", c, valid_out, pc_out,
                             inst_out, p, ins);
                else n_pass++;
            end else if (v) begin
                n_total++; if (valid_out !== 1'b0)
                    $display("FAIL rnd_consume c%0d got=%0b exp=0", c, valid_out); else n_pass++;
            end else if (valid_out) begin
                n_insts++;
                n_total++; if ({pc_out, inst_out} !== {exp_pc, mem_word(exp_pc)})
                    $display("FAIL rnd_order c%0d got=%h/%h exp=%h/%h", c, pc_out, inst_out, exp_pc,
                             mem_word(exp_pc));
                else n_pass++;
                exp_pc = exp_pc + 32'd4;
            end
        end
        n_total++; if (n_insts < 100) $display("FAIL rnd_progress got=%0d exp>=100", n_insts); else n_pass++;
        get_inst_in = 1'b0; stall_in = 1'b0; jump_in = 1'b0;
    endtask

`ifdef IF_ICACHE_EN
    task automatic test_icache();
        logic [31:0] a;
        do_reset();
        rst = 1'b0;
        tick();
        for (int pass = 0; pass < 2; pass++) begin
            for (int k = 0; k < 3; k++) begin
                a = k * 4;
                if (pass == 0) begin
                    get_inst_in = 1'b1; inst_pc_in = a; inst_in = mem_word(a);
                end
                #1;
                if (pass == 1) begin
                    n_total++; if (if_req_out !== 1'b0) $display("FAIL ic_hit_req a=%h got=%0b exp=0", a, if_req_out);
                    else n_pass++;
                end
                tick();
                get_inst_in = 1'b0;
                n_total++; if ({valid_out, pc_out, inst_out} !== {1'b1, a, mem_word(a)})
                    $display("FAIL ic_deliver p%0d got=%0b/%h/%h exp=1/%h/%h", pass, valid_out, pc_out,
                             inst_out, a, mem_word(a));
                else n_pass++;
                if (k == 2) begin
                    jump_in = 1'b1; jump_addr_in = 32'h0;
                end
                tick();
                jump_in = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_fetch();
        test_stall();
        test_jump_mid_fetch();
        test_jump_match();
        test_wrap();
        test_random();
`ifdef IF_ICACHE_EN
        test_icache();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the CPU pipeline, directly upstream of the memory controller's instruction port and feeding the IF/ID register. Holds the program counter, and issues a word read per instruction over the controller's level-held request / `get_inst` response protocol. It also absorbs pipeline stalls and redirects from jumps and branches, and can optionally serve repeat fetches from a small direct-mapped instruction cache.

## Interface
- `ICACHE_ENTRIES`, 16, number of cache lines (power of two, one 32-bit instruction per line); used only with `IF_ICACHE_EN`.
- Reset: `rst`, synchronous, active-high. Clock: `clk`. All state updates on the rising edge of `clk`.
- `clk`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `stall_in`  in  1  IF/ID cannot accept; hold current output
- `jump_in`  in  1  redirect request from EX
- `jump_addr_in`  in  32  redirect target; bits [1:0] ignored and treated as 0
- `mem_busy_in`  in  1  memory controller busy (informational; not used to gate the request)
- `get_inst_in`  in  1  controller has a fetched word (level, stays high until next IF accept)
- `inst_pc_in`  in  32  address of returned word
- `inst_in`  in  32  returned instruction
- `if_req_out`  out  1  fetch request, combinational
- `if_addr_out`  out  32  fetch address, equals `fetch_pc`
- `valid_out`  out  1  `pc_out` / `inst_out` hold a valid instruction
- `pc_out`  out  32  instruction address to IF/ID
- `inst_out`  out  32  instruction to IF/ID

## Operation
- Registers: `fetch_pc`, `state` (IDLE, FETCH, HOLD), the output registers, and the cache arrays when enabled.
- **Reset:** `fetch_pc`=0, `state`=IDLE, `valid_out`=0, `pc_out`=0, `inst_out`=0. Cache valid bits are cleared.
- **IDLE:** lasts one cycle after reset, then goes to FETCH.
- **FETCH:**
  - `if_req_out` = (state==FETCH) && !match && !hit && !jump_in.
  - match = `get_inst_in` && (`inst_pc_in` == `fetch_pc`).
  - On match: `pc_out`<=`fetch_pc`, `inst_out`<=`inst_in`, `valid_out`<=1, `fetch_pc`<=`fetch_pc`+4, go to HOLD.
  - A response with a mismatched PC is stale; ignore it and keep requesting.
- **HOLD:**
  - If `stall_in`=1, keep all outputs.
  - If `stall_in`=0, the word is consumed this edge: `valid_out`<=0, go to FETCH.
- **Jump** (any state, highest priority):
  - `fetch_pc`<={`jump_addr_in`[31:2],2'b00}, `valid_out`<=0, go to FETCH.
  - A response matching the old PC in the same cycle is discarded.
  - An in-flight controller read cannot be aborted. Its late `get_inst_in` carries the old PC and is rejected by the match rule.
- **Arithmetic:** `fetch_pc`+4 is a 32-bit add and wraps 0xFFFFFFFC→0x00000000.

## Timing
- `if_req_out` must be combinational. The controller samples it on the edge where `get_inst_in` first rises, so it must already be low in that same cycle, or the controller restarts the same fetch.
- **Miss latency:** `valid_out` rises on the edge after the first matching `get_inst_in` cycle.
- **Hold:** `valid_out` stays high for exactly the cycles of `stall_in`=1, plus one.
- Throughput is at most one instruction per two cycles (FETCH→HOLD→FETCH).
- **Jump and stall in the same cycle:** jump wins, and `valid_out` drops next edge.
- **Reset mid-fetch:** the state returns to IDLE. A later `get_inst_in` from the pre-reset read is stale unless `inst_pc_in`==0; in that case it is accepted, which is correct because it holds the same word.

## Configuration
- **`IF_ICACHE_EN` defined:**
  - Direct-mapped cache with `ICACHE_ENTRIES` lines, index `fetch_pc`[log2(N)+1:2], tag `fetch_pc`[31:log2(N)+2], one valid bit per line.
  - hit = (state==FETCH) && valid && tag equal. On a hit, behave as a match using the cached word, with no request issued: `valid_out` rises one edge after entering FETCH.
  - Every match fill writes data, tag and valid. There is no invalidation except reset, so self-modifying code is unsupported.
- **`IF_ICACHE_EN` undefined:** hit is constant 0, no arrays are built, and every instruction goes through the controller.

## Test plan
- **Reset then fetch:** reset, then `get_inst_in`=1 with `inst_pc_in`=0 and `inst_in`=0x00000013 after 6 cycles → `if_req_out` high from cycle 1 and low in the response cycle; next edge `valid_out`=1, `pc_out`=0, `inst_out`=0x13; `if_addr_out`=4 afterwards.
- **Stall:** `stall_in`=1 for 3 cycles during HOLD → `valid_out`, `pc_out` and `inst_out` are stable for 4 cycles, then a request for the next PC.
- **Jump mid-fetch:** `jump_in`=1 with `jump_addr_in`=0x100 while fetching 0x8; the late response with `inst_pc_in`=0x8 is ignored → `if_addr_out`=0x100, and `valid_out` stays 0 until the 0x100 response arrives.
- **Jump with simultaneous match:** matching response and `jump_in` in the same cycle → `valid_out` stays 0 and `fetch_pc`=target.
- **Wrap:** jump to 0xFFFFFFFC, deliver it → next `if_addr_out`=0x00000000.
- **`IF_ICACHE_EN` hit:** run the loop 0x0→0x4→0x8→jump 0x0 → the second pass issues no `if_req_out`, and `valid_out` rises one cycle after each FETCH entry with identical instructions.
